// File: rtl/int_timer.sv
// Programmable interval timer with one-shot / auto-reload modes, a maskable
// interrupt flag and a three-word register file (CTRL, PRESET, COUNT).
module int_timer #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        res,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t             state, state_nxt;
    logic               im, en;
    logic [1:0]         mode;
    logic [CNT_W-1:0]   preset, count, count_nxt;
    logic               int_flag;
    logic               flag_set, flag_auto_clr, en_clr;
    logic               wr_ctrl, wr_preset, auto_reload;

    assign wr_ctrl     = we && (addr == 2'd0);
    assign wr_preset   = we && (addr == 2'd1);
    // Only mode 1 reloads; the two unused encodings fall back to one-shot.
    assign auto_reload = (mode == 2'd1);

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        flag_set      = 1'b0;
        flag_auto_clr = 1'b0;
        en_clr        = 1'b0;
        case (state)
            S_IDLE: if (en) state_nxt = S_LOAD;
            S_LOAD: begin
                count_nxt = preset;
                state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_nxt = S_IDLE;
                end else if (count > CNT_W'(1)) begin
                    count_nxt = count - CNT_W'(1);
                end else begin
                    count_nxt = '0;
                    flag_set  = 1'b1;
                    state_nxt = S_INT;
                end
            end
            S_INT: begin
                state_nxt = S_IDLE;
                if (auto_reload) flag_auto_clr = 1'b1;
                else             en_clr        = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, matching the hardware's parallel update.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state    <= S_IDLE;
            count    <= '0;
            preset   <= '0;
            im       <= 1'b0;
            mode     <= 2'd0;
            en       <= 1'b0;
            int_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (wr_ctrl)     {im, mode, en} <= din[3:0];
            else if (en_clr) en <= 1'b0;
            if (wr_preset)   preset <= CNT_W'(din);
            // Setting the flag wins over any clear arriving on the same edge.
            if (flag_set)                                  int_flag <= 1'b1;
            else if (wr_ctrl || wr_preset || flag_auto_clr) int_flag <= 1'b0;
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            2'd0:    dout = {28'b0, im, mode, en};
            2'd1:    dout = 32'(preset);
            2'd2:    dout = 32'(count);
            default: dout = '0;
        endcase
    end

    assign irq = im & int_flag;

endmodule

// File: tb/tb_int_timer.sv
// Self-checking bench for int_timer: directed scenarios plus randomized runs
// compared against a closed-form timing model of the timer.
module tb_int_timer;

    logic        clk;
    logic        res;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int tests_run = 0;
    int tests_failed = 0;

    int_timer #(.CNT_W(32)) dut (
        .clk  (clk),
        .res  (res),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        din  = d;
        tick();
        we   = 1'b0;
        din  = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    // Stop any activity, let the FSM settle, then load PRESET and write CTRL (edge e0).
    task automatic start(input int n, input logic [3:0] ctrl);
        wr(2'd0, 32'h0);
        repeat (3) tick();
        wr(2'd1, 32'(n));
        wr(2'd0, {28'b0, ctrl});
    endtask

    // Reference: first expiry M+2 edges after enable (M = max(N,1)); LOAD lands
    // on edge 2 and then once every M+3 edges in auto-reload; COUNT after the
    // LOAD edge falls by one per edge, floored at zero.
    task automatic run_model(input string tag, input int n, input logic [3:0] ctrl, input int k_max);
        logic [31:0] obs;
        int m, p, j, exp_cnt;
        bit  auto, flag, en_exp;
        auto = (ctrl[2:1] == 2'd1);
        m    = (n == 0) ? 1 : n;
        p    = m + 3;
        start(n, ctrl);
        for (int k = 1; k <= k_max; k++) begin
            tick();
            flag   = 1'b0;
            en_exp = 1'b1;
            exp_cnt = 0;
            if (k >= 2) begin
                j = k - 2;
                if (auto) begin
                    j    = j % p;
                    flag = (j == m);
                end else begin
                    flag   = (j >= m);
                    en_exp = (k < m + 3);
                end
                exp_cnt = (n > j) ? n - j : 0;
                rd(2'd2, obs);
                check($sformatf("%s count k=%0d", tag, k), obs, 32'(exp_cnt));
            end
            rd(2'd0, obs);
            check($sformatf("%s ctrl k=%0d", tag, k), obs, {28'b0, ctrl[3:1], en_exp});
            check($sformatf("%s irq k=%0d", tag, k), {31'b0, irq}, {31'b0, ctrl[3] & flag});
        end
    endtask

    initial begin
        logic [31:0] obs;
        res  = 1'b1;
        we   = 1'b0;
        addr = 2'd0;
        din  = '0;

        // Power-on reset, checked before any clock edge
        #2 res = 1'b0;
        rd(2'd0, obs); check("por ctrl", obs, 32'h0);
        rd(2'd1, obs); check("por preset", obs, 32'h0);
        rd(2'd2, obs); check("por count", obs, 32'h0);
        check("por irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        res = 1'b1;
        tick();

        // One-shot: PRESET=3, CTRL=0x9
        run_model("oneshot", 3, 4'h9, 10);
        wr(2'd0, 32'h8);
        check("oneshot irq after ack", {31'b0, irq}, 32'h0);
        rd(2'd0, obs); check("oneshot ctrl after ack", obs, 32'h8);

        // Auto-reload: PRESET=2, CTRL=0xB, then stop with 0xA
        run_model("reload", 2, 4'hB, 16);
        wr(2'd0, 32'hA);
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("reload stopped irq k=%0d", k), {31'b0, irq}, 32'h0);
        end

        // Masked expiry: flag sets internally but irq stays low
        run_model("masked", 4, 4'h1, 12);

        // Disable mid-count: CTRL=0 on the edge that brings COUNT to 3
        start(4, 4'h1);
        tick(); tick();
        rd(2'd2, obs); check("disable count pre", obs, 32'd4);
        wr(2'd0, 32'h0);
        repeat (6) tick();
        rd(2'd2, obs); check("disable count held", obs, 32'd3);
        check("disable irq", {31'b0, irq}, 32'h0);

        // Writes to COUNT and the reserved word are ignored
        wr(2'd2, 32'hDEAD_BEEF);
        rd(2'd2, obs); check("count write ignored", obs, 32'd3);
        wr(2'd3, 32'h5);
        rd(2'd3, obs); check("reserved reads zero", obs, 32'h0);
        rd(2'd2, obs); check("count after reserved write", obs, 32'd3);

        // PRESET=0 expires on e3
        run_model("preset0", 0, 4'h9, 8);

        // PRESET rewritten mid-count: old expiry time, new value on next load
        start(5, 4'hB);
        repeat (5) tick();
        rd(2'd2, obs); check("rewrite count pre", obs, 32'd2);
        wr(2'd1, 32'd10);
        rd(2'd2, obs); check("rewrite count after write", obs, 32'd1);
        tick();
        check("rewrite irq at e7", {31'b0, irq}, 32'h1);
        tick();
        check("rewrite irq at e8", {31'b0, irq}, 32'h0);
        tick(); tick();
        rd(2'd2, obs); check("rewrite reload uses 10", obs, 32'd10);

        // Collision: CTRL write on the flag-set edge, flag set wins
        start(2, 4'h9);
        repeat (3) tick();
        wr(2'd0, 32'h9);
        check("collide set-wins irq", {31'b0, irq}, 32'h1);
        tick();
        rd(2'd0, obs); check("collide set-wins ctrl after INT", obs, 32'h8);

        // Collision: CTRL write on the INT edge keeps the written En
        start(2, 4'h9);
        repeat (4) tick();
        wr(2'd0, 32'h9);
        rd(2'd0, obs); check("collide int-edge en kept", obs, 32'h9);
        tick(); tick();
        rd(2'd2, obs); check("collide int-edge restart", obs, 32'd2);

        // Randomized runs against the timing model
        for (int t = 0; t < 8; t++) begin
            int n;
            logic [3:0] c;
            n = int'($urandom_range(0, 7));
            c = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1};
            run_model($sformatf("rand%0d n=%0d c=%h", t, n, c), n, c, 2 * (n + 4) + 4);
        end

        // Asynchronous reset in the middle of counting
        start(8, 4'h9);
        repeat (5) tick();
        rd(2'd2, obs); check("midreset count pre", obs, 32'd5);
        res = 1'b0;
        rd(2'd0, obs); check("midreset ctrl", obs, 32'h0);
        rd(2'd1, obs); check("midreset preset", obs, 32'h0);
        rd(2'd2, obs); check("midreset count", obs, 32'h0);
        check("midreset irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        res = 1'b1;
        repeat (6) tick();
        rd(2'd2, obs); check("post-reset count idle", obs, 32'h0);
        rd(2'd0, obs); check("post-reset ctrl idle", obs, 32'h0);
        check("post-reset irq", {31'b0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
